usb_nrzi_tx: RTL

- Transmit-side counterpart of the USB full-speed receive path.
- Accepts packet bytes over a valid/ready handshake, prepends SYNC, serializes LSB-first, inserts stuff bits, NRZI-encodes and terminates with EOP (SE0, SE0, J).
- Drives d_plus/d_minus toward the bus driver. Its output must round-trip through the existing NRZI decoder.

---
 rtl/usb_tx_pkg.sv | 28 ++
 rtl/usb_bit_timer.sv | 29 ++
 rtl/usb_nrzi_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and line-level constants for the USB full-speed transmit path.
// The NRZI helper is the single place that defines the J/K toggle rule.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         EOP_SE0_BITS = 2;

    // Line levels packed as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // A 0 toggles the line between J and K; a 1 holds the current level.
    function automatic logic [1:0] nrzi_next(input logic bit_val, input logic [1:0] cur);
        if (bit_val) return cur;
        return (cur == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled and flags the last
// cycle of each period with bit_tick. Held at zero while disabled.
module usb_bit_timer #(
    parameter int BIT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= 8'd0;
        end else if (count == LAST) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign bit_tick = en && (count == LAST);

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB full-speed transmitter: SYNC, LSB-first serialization, bit stuffing,
// NRZI encoding and EOP, fed from a one-entry hold register.
module usb_nrzi_tx
    import usb_tx_pkg::*;
#(
    parameter int BIT_CYCLES  = 8,
    parameter int STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_error
);

    localparam logic [7:0] ONES_LIMIT = 8'(STUFF_LIMIT);

    tx_state_e  state;
    logic [1:0] line;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_full;
    logic [7:0] shift_reg;
    logic       cur_last;
    logic [2:0] bit_cnt;
    logic [7:0] ones_cnt;
    logic [1:0] eop_cnt;
    logic       bit_tick;

    logic       load;
    logic [7:0] ones_next;
    logic       stuff_now;
    logic       byte_done;
    logic       pull;

    usb_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .bit_tick (bit_tick)
    );

    assign tx_ready = !hold_full;
    assign load     = tx_valid && tx_ready;
    assign d_plus   = line[1];
    assign d_minus  = line[0];

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        ones_next = shift_reg[0] ? ones_cnt + 8'd1 : 8'd0;
        stuff_now = (state == SYNC || state == DATA) && (ones_next == ONES_LIMIT);
        byte_done = (state == SYNC || state == DATA || state == STUFF)
                    && !stuff_now && (bit_cnt == 3'd7);
        pull      = bit_tick && byte_done && !cur_last && hold_full;
    end

    // NOTE: the hold payload is cleared on reset too, so a stale byte can never leak after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'd0;
            hold_last <= 1'b0;
        end else begin
            if (load) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
            end
            hold_full <= load || (hold_full && !pull);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line      <= LINE_J;
            tx_busy   <= 1'b0;
            tx_error  <= 1'b0;
            shift_reg <= 8'd0;
            cur_last  <= 1'b0;
            bit_cnt   <= 3'd0;
            ones_cnt  <= 8'd0;
            eop_cnt   <= 2'd0;
        end else begin
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state     <= SYNC;
                        shift_reg <= SYNC_BYTE;
                        cur_last  <= 1'b0;
                        bit_cnt   <= 3'd0;
                        ones_cnt  <= 8'd0;
                        line      <= nrzi_next(SYNC_BYTE[0], LINE_J);
                        tx_busy   <= 1'b1;
                    end
                end
                SYNC, DATA, STUFF: begin
                    if (bit_tick) begin
                        ones_cnt <= (state == STUFF || stuff_now) ? 8'd0 : ones_next;
                        if (stuff_now) begin
                            // Bit position is not advanced; STUFF resumes from here.
                            state <= STUFF;
                            line  <= nrzi_next(1'b0, line);
                        end else if (!byte_done) begin
                            if (state == STUFF) state <= DATA;
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                            line      <= nrzi_next(shift_reg[1], line);
                        end else if (cur_last) begin
                            state   <= EOP_SE0;
                            line    <= LINE_SE0;
                            eop_cnt <= 2'd0;
                        end else if (hold_full) begin
                            state     <= DATA;
                            shift_reg <= hold_data;
                            cur_last  <= hold_last;
                            bit_cnt   <= 3'd0;
                            line      <= nrzi_next(hold_data[0], line);
                        end else begin
                            tx_error <= 1'b1;
                            state    <= EOP_SE0;
                            line     <= LINE_SE0;
                            eop_cnt  <= 2'd0;
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_tick) begin
                        if (eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                            state <= EOP_J;
                            line  <= LINE_J;
                        end else begin
                            eop_cnt <= eop_cnt + 2'd1;
                        end
                    end
                end
                EOP_J: begin
                    if (bit_tick) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    line    <= LINE_J;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
